fpmul_param: RTL
================

FPMUL_PARAM -- requirements
Module: fpmul_param

Interface
REQ-001 SHALL have parameter EW, default 4: exponent field width, legal range 3..8.
REQ-002 SHALL have parameter MW, default 6: stored mantissa width, legal range 3..23; word width W = 1+EW+MW, so the default W is 11.
REQ-003 SHALL have the following ports; clk and rst_n are the only clock and reset.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operand pair a/b presented.
- in_ready  output  1  block accepts a/b this cycle.
- a  input  W  operand, {sign, exp, mant}, bias 2^(EW-1)-1.
- b  input  W  operand, same format as a.
- out_valid  output  1  product/flags valid.
- out_ready  input  1  consumer accepts the result.
- product  output  W  packed result.
- flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-004 SHALL be a 3-stage pipeline:
- S1: unpack, classify, sign XOR, biased exponent sum.
- S2: (MW+1)x(MW+1) significand multiply.
- S3: normalise, round, pack, flags.
REQ-005 SHALL deliver a transfer (in_valid&in_ready) as out_valid exactly 3 cycles later when out_ready stays high; sustained throughput SHALL be 1 result/cycle.
REQ-006 SHALL advance each stage only if the next stage is empty or advancing; in_ready = !S1_valid | S1_advance; no result SHALL be dropped, duplicated or reordered.
REQ-007 SHALL hold product and flags stable while out_valid=1 and out_ready=0.
REQ-008 SHALL treat exp=0 as zero: subnormal inputs flush to signed zero.
REQ-009 SHALL treat exp=all-ones as infinity when mant=0 and as NaN when mant!=0.
REQ-010 SHALL set product sign = sa^sb for all non-NaN results.
REQ-011 SHALL round significands to nearest, ties to even, using guard and sticky bits; inexact SHALL be set when any discarded bit is 1.
REQ-012 SHALL renormalise a mantissa carry-out from rounding by incrementing the exponent.
REQ-013 SHALL, when the biased result exponent >= 2^EW-1, output signed infinity with overflow=1 and inexact=1.
REQ-014 SHALL, when the biased result exponent <= 0, output signed zero with underflow=1, plus inexact=1 if the true result is nonzero.
REQ-015 SHALL, for inf x 0 or any NaN input, output canonical NaN {0, all-ones, 1 followed by zeros}; invalid SHALL be 1 only for inf x 0.
REQ-016 SHALL, for zero x finite, output signed zero with flags=0; for inf x nonzero, output signed inf with flags=0.

Reset
REQ-017 SHALL, on rst_n=0 asynchronously, clear all stage valid bits; out_valid=0, product=0, flags=0.
REQ-018 SHALL drive in_ready=0 during reset and in_ready=1 from the first clk edge after rst_n deasserts.
REQ-019 SHALL discard all in-flight operations on a mid-operation reset; no stale result SHALL appear after release.

Structure
REQ-020 SHALL place the flag bit-index constants, bias computation function and class enum (zero/normal/inf/nan) in shared package fpmul_pkg.
REQ-021 SHALL implement S3 in sub-module fpmul_norm_round, parametrised by EW and MW.
REQ-022 SHALL keep data registers unreset except the valid bits and the output registers.

Verification (default EW=4, MW=6)
REQ-023 Directed scenario: a=0x1E0, b=0x1E0 -> product=0x208, flags=0, out_valid 3 cycles after acceptance.
REQ-024 Directed scenario: a=0x5C0, b=0x1E0 -> product=0x5E0; a=0x1C1, b=0x1C1 -> product=0x1C2, inexact=1.
REQ-025 Directed scenario: a=0x380, b=0x380 -> product=0x3C0, overflow=1, inexact=1; a=0x3C0, b=0x000 -> product=0x3E0, invalid=1.
REQ-026 Directed scenario: a=0x040, b=0x040 -> product=0x000, underflow=1, inexact=1.
REQ-027 Directed scenario: continuous in_valid with out_ready=0 -> exactly 3 transfers accepted, then in_ready=0; after out_ready=1, results emerge in order at 1/cycle.
REQ-028 Directed scenario: rst_n pulsed low with 2 operations in flight -> out_valid=0 immediately; no result emerges after release.

Source files
------------

// File: rtl/fpmul_pkg.sv
// Shared definitions for the parametrised floating-point multiplier.
// Flag bit positions, exponent bias helper and operand classification.
// No logic; imported by the pipeline top and the normalise/round stage.
package fpmul_pkg;

  // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;
  localparam int FLG_W         = 4;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  // Exponent bias for an exponent field of width ew
  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

endpackage

// File: rtl/fpmul_norm_round.sv
// Third pipeline stage: normalise the significand product, round to nearest-even, pack, raise flags.
// Purely combinational; the enclosing pipeline registers the result.
// No flow control of its own; the top decides when the result is captured.
module fpmul_norm_round
  import fpmul_pkg::*;
#(
  parameter int EW = 4,
  parameter int MW = 6
) (
  input  logic              sign_i,
  input  fp_class_e         cls_a_i,
  input  fp_class_e         cls_b_i,
  input  logic [EW+1:0]     exp_i,   // biased exponent sum, two's complement
  input  logic [2*MW+1:0]   sig_i,   // (MW+1)x(MW+1) significand product
  output logic [EW+MW:0]    res_o,
  output logic [FLG_W-1:0]  flags_o
);

  localparam int EXW = EW + 2;
  localparam logic [EXW-1:0] EXP_MAX = EXW'((1 << EW) - 1);

  logic           hi;
  logic [2*MW:0]  norm;
  logic           guard, sticky, lsb, rnd_up;
  logic [MW:0]    mant_r;
  logic [EXW-1:0] exp_f;
  logic           ovf, unf;
  logic           inval, any_nan, any_inf, any_zero;

  // Normalise to 1.xxx, round to nearest-even and fold any rounding carry into the exponent
  always_comb begin
    hi     = sig_i[2*MW+1];
    // Hidden bit dropped; what remains is MW mantissa bits followed by the discarded bits
    norm   = hi ? sig_i[2*MW:0] : {sig_i[2*MW-1:0], 1'b0};
    lsb    = norm[MW+1];
    guard  = norm[MW];
    sticky = |norm[MW-1:0];
    rnd_up = guard & (sticky | lsb);
    mant_r = {1'b0, norm[2*MW:MW+1]} + {{MW{1'b0}}, rnd_up};
    // A carry out of rounding leaves mant_r[MW-1:0] all zero, i.e. 1.000 at the next exponent
    exp_f  = exp_i + EXW'(hi) + EXW'(mant_r[MW]);
    ovf    = !exp_f[EXW-1] && (exp_f >= EXP_MAX);
    unf    = exp_f[EXW-1] || (exp_f == '0);
  end

  // Special-operand priority: NaN/invalid, then infinity, then zero, then range checks
  always_comb begin
    inval    = (cls_a_i == CLS_INF && cls_b_i == CLS_ZERO) ||
               (cls_a_i == CLS_ZERO && cls_b_i == CLS_INF);
    any_nan  = (cls_a_i == CLS_NAN) || (cls_b_i == CLS_NAN) || inval;
    any_inf  = (cls_a_i == CLS_INF) || (cls_b_i == CLS_INF);
    any_zero = (cls_a_i == CLS_ZERO) || (cls_b_i == CLS_ZERO);
    res_o    = '0;
    flags_o  = '0;
    if (any_nan) begin
      res_o = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      flags_o[FLG_INVALID] = inval;
    end else if (any_inf) begin
      res_o = {sign_i, {EW{1'b1}}, {MW{1'b0}}};
    end else if (any_zero) begin
      res_o = {sign_i, {(EW+MW){1'b0}}};
    end else if (ovf) begin
      res_o = {sign_i, {EW{1'b1}}, {MW{1'b0}}};
      flags_o[FLG_OVERFLOW] = 1'b1;
      flags_o[FLG_INEXACT]  = 1'b1;
    end else if (unf) begin
      // Both operands are normal here, so the true product is never zero
      res_o = {sign_i, {(EW+MW){1'b0}}};
      flags_o[FLG_UNDERFLOW] = 1'b1;
      flags_o[FLG_INEXACT]   = 1'b1;
    end else begin
      res_o = {sign_i, exp_f[EW-1:0], mant_r[MW-1:0]};
      flags_o[FLG_INEXACT] = guard | sticky;
    end
  end

endmodule

// File: rtl/fpmul_param.sv
// Parametrised floating-point multiplier: unpack/classify, significand multiply, normalise/round/pack.
// Latency 3 cycles from acceptance to out_valid, one result per cycle sustained.
// Valid/ready pipeline: each stage advances only when the next is empty or advancing; output holds under stall.
module fpmul_param
  import fpmul_pkg::*;
#(
  parameter int EW = 4,
  parameter int MW = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   a,
  input  logic [EW+MW:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   product,
  output logic [FLG_W-1:0] flags
);

  localparam int W   = 1 + EW + MW;
  localparam int EXW = EW + 2;
  localparam int SW  = 2 * MW + 2;
  localparam logic [EXW-1:0] BIAS = EXW'(fp_bias(EW));

  function automatic fp_class_e classify(input logic [EW-1:0] e, input logic [MW-1:0] m);
    if (e == '0)      return CLS_ZERO;
    else if (e == '1) return (m == '0) ? CLS_INF : CLS_NAN;
    else              return CLS_NORM;
  endfunction

  logic ready_en_q;
  logic s1_valid_q, s2_valid_q, out_valid_q;
  logic out_free, s2_free, s1_adv, s2_adv, accept;

  logic            s1_sign_q, s2_sign_q;
  fp_class_e       s1_cls_a_q, s1_cls_b_q, s2_cls_a_q, s2_cls_b_q;
  fp_class_e       cls_a_d, cls_b_d;
  logic [EXW-1:0]  s1_exp_q, s1_exp_d, s2_exp_q;
  logic [MW:0]     s1_ma_q, s1_mb_q;
  logic [SW-1:0]   s2_sig_q, s2_sig_d;
  logic [W-1:0]    product_q, s3_res;
  logic [FLG_W-1:0] flags_q, s3_flags;

  // Handshake: a stage may load when it is empty or its content moves on this cycle
  always_comb begin
    out_free = !out_valid_q || out_ready;
    s2_free  = !s2_valid_q || out_free;
    s2_adv   = s2_valid_q && out_free;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = ready_en_q && (!s1_valid_q || s2_free);
    accept   = in_valid && in_ready;
  end

  // S1/S2 combinational work: classify, exponent sum, significand product
  always_comb begin
    cls_a_d  = classify(a[W-2:MW], a[MW-1:0]);
    cls_b_d  = classify(b[W-2:MW], b[MW-1:0]);
    s1_exp_d = {2'b00, a[W-2:MW]} + {2'b00, b[W-2:MW]} - BIAS;
    s2_sig_d = {{(MW+1){1'b0}}, s1_ma_q} * {{(MW+1){1'b0}}, s1_mb_q};
  end

  // Hold off acceptance until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  // Stage valid bits; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q  <= in_valid;
      if (s2_free)  s2_valid_q  <= s1_valid_q;
      if (out_free) out_valid_q <= s2_valid_q;
    end
  end

  // Pipeline data registers, loaded only when their stage takes a new operation
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sign_q  <= a[W-1] ^ b[W-1];
      s1_cls_a_q <= cls_a_d;
      s1_cls_b_q <= cls_b_d;
      s1_exp_q   <= s1_exp_d;
      s1_ma_q    <= {1'b1, a[MW-1:0]};
      s1_mb_q    <= {1'b1, b[MW-1:0]};
    end
    if (s1_adv) begin
      s2_sign_q  <= s1_sign_q;
      s2_cls_a_q <= s1_cls_a_q;
      s2_cls_b_q <= s1_cls_b_q;
      s2_exp_q   <= s1_exp_q;
      s2_sig_q   <= s2_sig_d;
    end
  end

  fpmul_norm_round #(.EW(EW), .MW(MW)) u_norm_round (
    .sign_i  (s2_sign_q),
    .cls_a_i (s2_cls_a_q),
    .cls_b_i (s2_cls_b_q),
    .exp_i   (s2_exp_q),
    .sig_i   (s2_sig_q),
    .res_o   (s3_res),
    .flags_o (s3_flags)
  );

  // Output registers; unchanged while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q <= '0;
      flags_q   <= '0;
    end else if (s2_adv) begin
      product_q <= s3_res;
      flags_q   <= s3_flags;
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign flags     = flags_q;

endmodule
